// File: rtl/uart_program_loader_if.sv
// uart_program_loader_if: instruction-memory write port plus loader status flags
interface uart_program_loader_if;
  logic [31:0] write_instr_data;
  logic        write_instr_valid;
  logic [31:0] write_byte_address;
  logic        start;
  logic        load_error;
  modport master (output write_instr_data, write_instr_valid, write_byte_address, start, load_error);
  modport slave  (input  write_instr_data, write_instr_valid, write_byte_address, start, load_error);
endinterface

// File: rtl/uart_program_loader.sv
// uart_program_loader: 8N1 UART boot loader writing a little-endian program image into instruction memory
module uart_program_loader #(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD      = 115_200,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_serial,
  uart_program_loader_if.master wr
);
  localparam int unsigned CPB = CLK_FREQ / BAUD;
  localparam int unsigned CW  = $clog2(CPB) + 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CPB - 1);
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {L_HDR, L_DATA, L_DONE, L_ERR} ld_state_e;
  logic [1:0]    sync_q;
  logic          rx_s;
  rx_state_e     rx_q, rx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          byte_valid_q, byte_valid_d, frame_err_q, frame_err_d;
  ld_state_e     ld_q, ld_d;
  logic [1:0]    idx_q, idx_d;
  logic [31:0]   asm_q, asm_d, wc_q, wc_d, wi_q, wi_d, data_q, data_d, addr_q, addr_d;
  logic          valid_q, valid_d, start_q, start_d, err_q, err_d;
  logic [31:0]   word;
  logic          in_load, last_byte;
  assign rx_s = sync_q[1];
  always_comb begin
    rx_d         = rx_q;
    cnt_d        = cnt_q + 1'b1;
    bit_d        = bit_q;
    sh_d         = sh_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (rx_q)
      RX_IDLE: begin
        cnt_d = '0;
        rx_d  = rx_s ? RX_IDLE : RX_START;
      end
      RX_START: if (cnt_q == HALF_M1) begin
        cnt_d = '0;
        bit_d = '0;
        rx_d  = rx_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (cnt_q == FULL_M1) begin
        cnt_d = '0;
        sh_d  = {rx_s, sh_q[7:1]};
        bit_d = bit_q + 3'd1;
        rx_d  = (bit_q == 3'd7) ? RX_STOP : RX_DATA;
      end
      default: if (cnt_q == FULL_M1) begin
        cnt_d        = '0;
        rx_d         = RX_IDLE;
        byte_valid_d = rx_s;
        frame_err_d  = !rx_s;
      end
    endcase
  end
  // the received byte stays in sh_q until the next frame's first data sample
  assign word      = {sh_q, asm_q[31:8]};
  assign in_load   = (ld_q == L_HDR) || (ld_q == L_DATA);
  assign last_byte = byte_valid_q && idx_q == 2'd3;
  always_comb begin
    ld_d    = ld_q;
    idx_d   = idx_q;
    asm_d   = asm_q;
    wc_d    = wc_q;
    wi_d    = wi_q;
    data_d  = data_q;
    addr_d  = addr_q;
    valid_d = 1'b0;
    start_d = start_q;
    err_d   = err_q;
    if (frame_err_q && in_load) begin
      ld_d  = L_ERR;
      err_d = 1'b1;
    end else if (byte_valid_q && in_load) begin
      asm_d = word;
      idx_d = idx_q + 2'd1;
      if (last_byte && ld_q == L_HDR) begin
        wc_d    = word;
        ld_d    = (word == '0) ? L_DONE : (word > MAX_WORDS) ? L_ERR : L_DATA;
        start_d = word == '0;
        err_d   = word > MAX_WORDS;
      end else if (last_byte) begin
        data_d  = word;
        addr_d  = wi_q << 2;
        valid_d = 1'b1;
        wi_d    = wi_q + 32'd1;
        ld_d    = (wi_q + 32'd1 == wc_q) ? L_DONE : L_DATA;
        start_d = wi_q + 32'd1 == wc_q;
      end
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sync_q       <= 2'b11;
      rx_q         <= RX_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      sh_q         <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      ld_q         <= L_HDR;
      idx_q        <= '0;
      asm_q        <= '0;
      wc_q         <= '0;
      wi_q         <= '0;
      data_q       <= '0;
      addr_q       <= '0;
      valid_q      <= 1'b0;
      start_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], rx_serial};
      rx_q         <= rx_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      sh_q         <= sh_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      ld_q         <= ld_d;
      idx_q        <= idx_d;
      asm_q        <= asm_d;
      wc_q         <= wc_d;
      wi_q         <= wi_d;
      data_q       <= data_d;
      addr_q       <= addr_d;
      valid_q      <= valid_d;
      start_q      <= start_d;
      err_q        <= err_d;
    end
  assign wr.write_instr_data   = data_q;
  assign wr.write_instr_valid  = valid_q;
  assign wr.write_byte_address = addr_q;
  assign wr.start              = start_q;
  assign wr.load_error         = err_q;
endmodule

// File: tb/tb_uart_program_loader.sv
// tb_uart_program_loader: randomized UART boot-load scenarios checked against a byte-stream model
module tb_uart_program_loader;
  localparam int CPB  = 16;
  localparam int MAXW = 4;
  logic clk = 0, rst = 0, rx = 1;
  int cyc = 0, tests = 0, fails = 0, last_edge = 0;
  uart_program_loader_if bus();
  uart_program_loader #(.CLK_FREQ(16), .BAUD(1), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst(rst), .rx_serial(rx), .wr(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  logic [31:0] got_d[$], got_a[$], exp_d[$], exp_a[$];
  int          got_c[$];
  int          start_cyc = -1;
  logic        start_prev = 0, exp_start, exp_err;
  logic [7:0]  tx[$];
  always @(negedge clk) begin
    if (bus.write_instr_valid) begin
      got_d.push_back(bus.write_instr_data);
      got_a.push_back(bus.write_byte_address);
      got_c.push_back(cyc);
    end
    if (bus.start && !start_prev) start_cyc = cyc;
    start_prev = bus.start;
  end
  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 0;
    last_edge = cyc;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1;
  endtask
  task automatic send_all(input int max_gap);
    foreach (tx[i]) begin
      send_byte(tx[i], 1'b1);
      repeat ($urandom_range(0, max_gap)) @(negedge clk);
    end
    repeat (CPB) @(negedge clk);
  endtask
  task automatic clear_mon();
    got_d.delete(); got_a.delete(); got_c.delete();
    start_cyc = -1;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 0;
    rx = 1;
    repeat (3) @(negedge clk);
    clear_mon();
    rst = 1;
    repeat (4) @(negedge clk);
  endtask
  // expected behaviour derived straight from the byte stream
  task automatic model();
    logic [31:0] wc;
    exp_d.delete(); exp_a.delete();
    wc = {tx[3], tx[2], tx[1], tx[0]};
    exp_err = wc > MAXW;
    exp_start = !exp_err && tx.size() >= 4 + 4 * int'(wc);
    if (!exp_err)
      for (int i = 0; i < int'(wc) && 4 * i + 7 < tx.size(); i++) begin
        exp_d.push_back({tx[4*i+7], tx[4*i+6], tx[4*i+5], tx[4*i+4]});
        exp_a.push_back(32'(i * 4));
      end
  endtask
  task automatic test_reset();
    tests++;
    if ({bus.write_instr_data, bus.write_instr_valid, bus.write_byte_address, bus.start, bus.load_error} !== '0) begin
      fails++;
      $display("FAIL reset outputs: got d=%h v=%b a=%h s=%b e=%b, want all 0", bus.write_instr_data,
               bus.write_instr_valid, bus.write_byte_address, bus.start, bus.load_error);
    end
  endtask
  task automatic test_two_word();
    do_reset();
    tx = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h73, 8'h00, 8'h10, 8'h00};
    send_all(2 * CPB);
    tests++;
    if (got_d.size() != 2) begin
      fails++; $display("FAIL two_word count: got %0d want 2", got_d.size());
    end else begin
      tests++;
      if (got_d[0] !== 32'h00A00513 || got_a[0] !== 32'h0) begin
        fails++; $display("FAIL two_word strobe1: got %h@%h want 00a00513@0", got_d[0], got_a[0]);
      end
      tests++;
      if (got_d[1] !== 32'h00100073 || got_a[1] !== 32'h4) begin
        fails++; $display("FAIL two_word strobe2: got %h@%h want 00100073@4", got_d[1], got_a[1]);
      end
      tests++;
      if (start_cyc != got_c[1]) begin
        fails++; $display("FAIL two_word start_cycle: got %0d want %0d", start_cyc, got_c[1]);
      end
    end
    tests++;
    if (bus.start !== 1'b1 || bus.load_error !== 1'b0) begin
      fails++; $display("FAIL two_word flags: got s=%b e=%b want s=1 e=0", bus.start, bus.load_error);
    end
  endtask
  task automatic test_empty();
    do_reset();
    tx = '{8'h00, 8'h00, 8'h00, 8'h00};
    send_all(CPB);
    tests++;
    if (got_d.size() != 0 || bus.start !== 1'b1 || bus.load_error !== 1'b0) begin
      fails++; $display("FAIL empty: got n=%0d s=%b e=%b want n=0 s=1 e=0", got_d.size(), bus.start, bus.load_error);
    end
    tests++;
    if (start_cyc < last_edge + 155 || start_cyc > last_edge + 158) begin
      fails++; $display("FAIL empty start_cycle: got %0d want %0d..%0d", start_cyc, last_edge + 155, last_edge + 158);
    end
  endtask
  task automatic test_oversize();
    do_reset();
    tx = '{8'h05, 8'h00, 8'h00, 8'h00};
    repeat (20) tx.push_back(8'($urandom));
    send_all(CPB);
    tests++;
    if (got_d.size() != 0 || bus.start !== 1'b0 || bus.load_error !== 1'b1) begin
      fails++; $display("FAIL oversize: got n=%0d s=%b e=%b want n=0 s=0 e=1", got_d.size(), bus.start, bus.load_error);
    end
  endtask
  task automatic test_framing();
    do_reset();
    tx = '{8'h02, 8'h00, 8'h00, 8'h00};
    send_all(CPB);
    send_byte(8'($urandom), 1'b1);
    send_byte(8'($urandom), 1'b0);
    repeat (2 * CPB) @(negedge clk);
    tx.delete();
    repeat (6) tx.push_back(8'($urandom));
    send_all(CPB);
    tests++;
    if (got_d.size() != 0 || bus.start !== 1'b0 || bus.load_error !== 1'b1) begin
      fails++; $display("FAIL framing: got n=%0d s=%b e=%b want n=0 s=0 e=1", got_d.size(), bus.start, bus.load_error);
    end
  endtask
  task automatic test_glitch_back_to_back();
    do_reset();
    rx = 0;
    repeat (3) @(negedge clk);
    rx = 1;
    repeat (2 * CPB) @(negedge clk);
    tests++;
    if (bus.load_error !== 1'b0 || got_d.size() != 0) begin
      fails++; $display("FAIL glitch: got e=%b n=%0d want e=0 n=0", bus.load_error, got_d.size());
    end
    tx = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_all(0);
    tests++;
    if (got_d.size() != 1 || got_d[0] !== 32'hDEADBEEF || got_a[0] !== 32'h0) begin
      fails++; $display("FAIL back_to_back: got n=%0d d=%h a=%h want n=1 d=deadbeef a=0", got_d.size(),
                        got_d.size() ? got_d[0] : 32'h0, got_a.size() ? got_a[0] : 32'h0);
    end
    tests++;
    if (bus.start !== 1'b1 || bus.load_error !== 1'b0) begin
      fails++; $display("FAIL back_to_back flags: got s=%b e=%b want s=1 e=0", bus.start, bus.load_error);
    end
  endtask
  task automatic test_reset_mid_load();
    do_reset();
    tx = '{8'h03, 8'h00, 8'h00, 8'h00};
    repeat (6) tx.push_back(8'($urandom) | 8'h01);
    send_all(CPB);
    rx = 0;
    repeat (5 * CPB) @(negedge clk);
    #2 rst = 0;
    #1;
    tests++;
    if ({bus.write_instr_data, bus.write_instr_valid, bus.write_byte_address, bus.start, bus.load_error} !== '0) begin
      fails++; $display("FAIL reset_mid outputs: got d=%h a=%h s=%b e=%b want all 0", bus.write_instr_data,
                        bus.write_byte_address, bus.start, bus.load_error);
    end
    rx = 1;
    repeat (3) @(negedge clk);
    clear_mon();
    rst = 1;
    repeat (2 * CPB) @(negedge clk);
    tx = '{8'h03, 8'h00, 8'h00, 8'h00};
    repeat (12) tx.push_back(8'($urandom));
    send_all(CPB);
    model();
    tests++;
    if (got_d.size() != 3) begin
      fails++; $display("FAIL reload count: got %0d want 3", got_d.size());
    end else
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (got_d[i] !== exp_d[i] || got_a[i] !== 32'(4 * i)) begin
          fails++; $display("FAIL reload word%0d: got %h@%h want %h@%h", i, got_d[i], got_a[i], exp_d[i], 32'(4 * i));
        end
      end
    tx.delete();
    repeat (4) tx.push_back(8'($urandom));
    send_all(CPB);
    tests++;
    if (got_d.size() != 3 || bus.start !== 1'b1 || bus.load_error !== 1'b0) begin
      fails++; $display("FAIL post_done: got n=%0d s=%b e=%b want n=3 s=1 e=0", got_d.size(), bus.start, bus.load_error);
    end
  endtask
  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      int wc;
      wc = (it == 0) ? MAXW : $urandom_range(1, MAXW);
      do_reset();
      tx = '{8'(wc), 8'h00, 8'h00, 8'h00};
      repeat (4 * wc) tx.push_back(8'($urandom));
      send_all(3 * CPB);
      model();
      tests++;
      if (got_d.size() != exp_d.size()) begin
        fails++; $display("FAIL random%0d count: got %0d want %0d", it, got_d.size(), exp_d.size());
      end else begin
        foreach (exp_d[i]) begin
          tests++;
          if (got_d[i] !== exp_d[i] || got_a[i] !== exp_a[i]) begin
            fails++; $display("FAIL random%0d word%0d: got %h@%h want %h@%h", it, i, got_d[i], got_a[i], exp_d[i], exp_a[i]);
          end
        end
        tests++;
        if (start_cyc != got_c[got_c.size()-1]) begin
          fails++; $display("FAIL random%0d start_cycle: got %0d want %0d", it, start_cyc, got_c[got_c.size()-1]);
        end
      end
      tests++;
      if (bus.start !== exp_start || bus.load_error !== exp_err) begin
        fails++; $display("FAIL random%0d flags: got s=%b e=%b want s=%b e=%b", it, bus.start, bus.load_error, exp_start, exp_err);
      end
    end
  endtask
  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_two_word();
    test_empty();
    test_oversize();
    test_framing();
    test_glitch_back_to_back();
    test_reset_mid_load();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
